// File: rtl/mult_operand_driver.sv
// rtl/mult_operand_driver.sv - operand FIFO and start/done sequencer for the 8x8 sequential multiplier
// Optional RUN watchdog enabled by defining MULT_DRV_TIMEOUT_EN.
module mult_operand_driver #(
    parameter int FIFO_DEPTH = 2
`ifdef MULT_DRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 8
`endif
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        start,
    output logic [7:0]  dataa,
    output logic [7:0]  datab,
    input  logic        done,
    input  logic [2:0]  state_in,
    input  logic [15:0] product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_product,
    output logic        out_err,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] MULT_ERR_STATE = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       mem_a [FIFO_DEPTH];
    logic [7:0]       mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             push, pop;

    logic             start_nxt;
    logic             out_valid_nxt;
    logic [15:0]      out_product_nxt;
    logic             out_err_nxt;

`ifdef MULT_DRV_TIMEOUT_EN
    localparam logic [3:0] WD_LAST = 4'(TIMEOUT - 1);
    logic [3:0] wd, wd_nxt;
`endif

    // in_ready comes from the registered count only, so a pop never frees a slot in the same cycle
    assign in_ready   = (count != DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = in_valid & in_ready;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        start_nxt       = 1'b0;
        pop             = 1'b0;
        out_valid_nxt   = out_valid;
        out_product_nxt = out_product;
        out_err_nxt     = out_err;
`ifdef MULT_DRV_TIMEOUT_EN
        wd_nxt          = wd;
`endif
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
`ifdef MULT_DRV_TIMEOUT_EN
                wd_nxt    = 4'd0;
`endif
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // done wins over a simultaneous error state from the multiplier control
                if (done) begin
                    out_product_nxt = product;
                    out_err_nxt     = 1'b0;
                    out_valid_nxt   = 1'b1;
                    state_nxt       = S_HOLD;
                end else if (state_in == MULT_ERR_STATE) begin
                    out_product_nxt = 16'h0000;
                    out_err_nxt     = 1'b1;
                    out_valid_nxt   = 1'b1;
                    state_nxt       = S_HOLD;
                end
`ifdef MULT_DRV_TIMEOUT_EN
                else if (wd == WD_LAST) begin
                    out_product_nxt = 16'h0000;
                    out_err_nxt     = 1'b1;
                    out_valid_nxt   = 1'b1;
                    state_nxt       = S_HOLD;
                end else begin
                    wd_nxt = wd + 4'd1;
                end
`endif
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        start_nxt = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state       <= S_IDLE;
            start       <= 1'b0;
            dataa       <= 8'h00;
            datab       <= 8'h00;
            out_valid   <= 1'b0;
            out_product <= 16'h0000;
            out_err     <= 1'b0;
`ifdef MULT_DRV_TIMEOUT_EN
            wd          <= 4'd0;
`endif
        end else begin
            state       <= state_nxt;
            start       <= start_nxt;
            out_valid   <= out_valid_nxt;
            out_product <= out_product_nxt;
            out_err     <= out_err_nxt;
`ifdef MULT_DRV_TIMEOUT_EN
            wd          <= wd_nxt;
`endif
            if (pop) begin
                dataa <= mem_a[rd_ptr];
                datab <= mem_b[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_driver.sv
// tb/tb_mult_operand_driver.sv - directed self-checking bench for mult_operand_driver
module tb_mult_operand_driver;

    logic        clk;
    logic        reset_a;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic        start;
    logic [7:0]  dataa, datab;
    logic        done;
    logic [2:0]  state_in;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic        err_mode, nodone_mode;
    logic [3:0]  mcnt;

    logic [15:0] rp_q [$];
    logic        re_q [$];
    int          rc_q [$];
    int          st_q [$];

    mult_operand_driver dut (
        .clk(clk), .reset_a(reset_a),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .start(start), .dataa(dataa), .datab(datab),
        .done(done), .state_in(state_in), .product(product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_err(out_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // multiplier control model: done in the 5th RUN cycle, error state from the 2nd RUN cycle
    always @(posedge clk or negedge reset_a) begin
        if (!reset_a)                      mcnt <= 4'd0;
        else if (start)                    mcnt <= 4'd1;
        else if (mcnt != 0 && mcnt != 15)  mcnt <= mcnt + 4'd1;
    end
    assign done     = (mcnt == 4'd5) && !err_mode && !nodone_mode;
    assign state_in = (err_mode && mcnt >= 4'd2) ? 3'b101 : 3'b010;
    assign product  = done ? (16'(dataa) * 16'(datab)) : 16'hBEEF;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            rp_q.push_back(out_product);
            re_q.push_back(out_err);
            rc_q.push_back(cyc);
        end
        if (start) st_q.push_back(cyc);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        rp_q.delete(); re_q.delete(); rc_q.delete(); st_q.delete();
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, output int acc);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_res(input string tag, input int n);
        int t;
        t = 0;
        while (rp_q.size() < n && t < 80) begin
            tick;
            t++;
        end
        chk(tag, (rp_q.size() >= n), 1);
        while (rp_q.size() < n) begin
            rp_q.push_back('x); re_q.push_back(1'bx); rc_q.push_back(-1000);
        end
        while (st_q.size() < n) st_q.push_back(-2000);
    endtask

    task automatic wait_valid(output int c);
        int t;
        t = 0;
        while (!out_valid && t < 80) begin
            tick;
            t++;
        end
        c = cyc;
    endtask

    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic [15:0] tp [4];

    initial begin
        int ca, cv, waited;
        ta[0] = 8'h01; tb[0] = 8'h02; tp[0] = 16'h0002;
        ta[1] = 8'h10; tb[1] = 8'h10; tp[1] = 16'h0100;
        ta[2] = 8'h80; tb[2] = 8'h02; tp[2] = 16'h0100;
        ta[3] = 8'h00; tb[3] = 8'h55; tp[3] = 16'h0000;

        reset_a = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b1; err_mode = 1'b0; nodone_mode = 1'b0;
        tick; tick;
        chk("rst_start", start, 0);
        chk("rst_dataa", dataa, 8'h00);
        chk("rst_datab", datab, 8'h00);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_product", out_product, 16'h0000);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_a = 1'b1;
        tick;

        // 0x0F * 0x0F, result ready immediately
        clr();
        push(8'h0F, 8'h0F, ca);
        wait_res("t1_result", 1);
        chk("t1_latency", rc_q[0] - ca, 7);
        chk("t1_product", rp_q[0], 16'h00E1);
        chk("t1_err", re_q[0], 0);
        chk("t1_start_count", st_q.size(), 1);
        chk("t1_start_cycle", st_q[0] - ca, 1);
        tick;
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_idle", busy, 0);

        // 0xFF * 0xFF with back-pressure
        clr();
        out_ready = 1'b0;
        push(8'hFF, 8'hFF, ca);
        wait_valid(cv);
        chk("t2_latency", cv - ca, 7);
        chk("t2_product", out_product, 16'hFE01);
        chk("t2_err", out_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_product", out_product, 16'hFE01);
            chk("t2_hold_start", start, 0);
        end
        chk("t2_no_new_start", st_q.size(), 1);
        out_ready = 1'b1;
        tick;
        chk("t2_valid_drop", out_valid, 0);

        // four pairs back-to-back into a 2-deep FIFO
        clr();
        waited = 0;
        for (int i = 0; i < 4; i++) begin
            in_a = ta[i]; in_b = tb[i]; in_valid = 1'b1;
            if (i == 3) chk("t3_full_on_4th", in_ready, 0);
            while (!in_ready && waited < 40) begin
                tick;
                waited++;
            end
            tick;
        end
        in_valid = 1'b0;
        chk("t3_full_wait", waited, 6);
        wait_res("t3_results", 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_product%0d", i), rp_q[i], tp[i]);
            chk($sformatf("t3_err%0d", i), re_q[i], 0);
        end
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t3_result_gap%0d", i), rc_q[i] - rc_q[i-1], 7);
            chk($sformatf("t3_start_gap%0d", i), st_q[i] - st_q[i-1], 7);
        end
        tick;

        // multiplier enters its error state, then recovers on the next pair
        clr();
        err_mode = 1'b1;
        push(8'h07, 8'h09, ca);
        wait_res("t4_err_result", 1);
        chk("t4_err_product", rp_q[0], 16'h0000);
        chk("t4_err_flag", re_q[0], 1);
        chk("t4_err_latency", rc_q[0] - st_q[0], 3);
        err_mode = 1'b0;
        tick;
        push(8'h03, 8'h05, ca);
        wait_res("t4_next_result", 2);
        chk("t4_next_product", rp_q[1], 16'h000F);
        chk("t4_next_err", re_q[1], 0);
        chk("t4_next_latency", rc_q[1] - st_q[1], 6);
        tick;

        // missing done
        clr();
        nodone_mode = 1'b1;
        push(8'h02, 8'h03, ca);
`ifdef MULT_DRV_TIMEOUT_EN
        wait_res("t5_timeout_result", 1);
        chk("t5_timeout_product", rp_q[0], 16'h0000);
        chk("t5_timeout_err", re_q[0], 1);
        chk("t5_timeout_latency", rc_q[0] - st_q[0], 9);
`else
        repeat (50) tick;
        chk("t5_no_result", rp_q.size(), 0);
        chk("t5_no_valid", out_valid, 0);
        chk("t5_busy", busy, 1);
`endif
        nodone_mode = 1'b0;

        // reset during RUN with two pairs queued
        reset_a = 1'b0;
        tick;
        reset_a = 1'b1;
        tick;
        push(8'h11, 8'h22, ca);
        push(8'h33, 8'h44, ca);
        push(8'h55, 8'h66, ca);
        tick;
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_full", in_ready, 0);
        reset_a = 1'b0;
        #1;
        clr();
        chk("t6_start", start, 0);
        chk("t6_dataa", dataa, 8'h00);
        chk("t6_datab", datab, 8'h00);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_product", out_product, 16'h0000);
        chk("t6_out_err", out_err, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 1);
        tick; tick;
        reset_a = 1'b1;
        repeat (20) tick;
        chk("t6_no_stale_result", rp_q.size(), 0);
        chk("t6_no_stale_start", st_q.size(), 0);
        chk("t6_idle_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
